// File: rtl/knock_seq_gen_pkg.sv
// Shared definitions for the knock sequence generator and the knock detector.
// The bus command codes and the door words live here so both sides see the same values.
package knock_seq_gen_pkg;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_command_t;

   // OPEN knock: seven words, stored in this order
   localparam logic [63:0] DOOR1 = 64'h123f_45a6_f8e2_b6c4;
   localparam logic [63:0] DOOR2 = 64'h2a5c_3d7e_9b10_f4e8;
   localparam logic [63:0] DOOR3 = 64'h0000_1111_cccc_1111;
   localparam logic [63:0] DOOR4 = 64'h7e6d_5c4b_3a29_1807;
   localparam logic [63:0] DOOR5 = 64'ha5a5_5a5a_0ff0_f00f;
   localparam logic [63:0] DOOR6 = 64'hfedc_ba98_7654_3210;
   localparam logic [63:0] DOOR7 = 64'h1348_7aba_cdd4_5487;

   // CLOSE knock: three words
   localparam logic [63:0] CLOSE_DOOR1 = 64'h0011_0011_0011_0011;
   localparam logic [63:0] CLOSE_DOOR2 = 64'h1100_1100_1100_1100;
   localparam logic [63:0] CLOSE_DOOR3 = 64'hffaa_ffbb_ffcc_ffdd;

   // Index of the final word of each sequence
   localparam logic [2:0] OPEN_LAST_INDEX  = 3'd6;
   localparam logic [2:0] CLOSE_LAST_INDEX = 3'd2;

   typedef enum logic [2:0] {
      KG_IDLE  = 3'd0,
      KG_REQ   = 3'd1,
      KG_STORE = 3'd2,
      KG_GAP   = 3'd3,
      KG_DONE  = 3'd4
   } kg_state_t;

endpackage

// File: rtl/knock_seq_gen_if.sv
// Store-bus bundle between the knock generator (master) and the arbiter/Dmem side (slave).
interface knock_seq_gen_if;
   import knock_seq_gen_pkg::*;

   logic         bus_grant;
   logic [3:0]   Dmem2gen_response;
   logic         gen_bus_req;
   bus_command_t gen2Dmem_command;
   logic [63:0]  gen2Dmem_addr;
   logic [63:0]  gen2Dmem_data;

   modport master (
      input  bus_grant,
      input  Dmem2gen_response,
      output gen_bus_req,
      output gen2Dmem_command,
      output gen2Dmem_addr,
      output gen2Dmem_data
   );

   modport slave (
      output bus_grant,
      output Dmem2gen_response,
      input  gen_bus_req,
      input  gen2Dmem_command,
      input  gen2Dmem_addr,
      input  gen2Dmem_data
   );

endinterface

// File: rtl/knock_seq_gen.sv
// Knock sequence generator: on open_req/close_req it stores the OPEN or CLOSE door
// words to consecutive doublewords at BASE_ADDR, one accepted store at a time.
// All bus outputs are decoded from registered state only.
module knock_seq_gen
   import knock_seq_gen_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0000_1000,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            open_req,
   input  logic            close_req,
   knock_seq_gen_if.master bus,
   output logic            busy,
   output logic            done,
   output logic            seq_is_close
);

   // Final value of the gap counter before returning to STORE
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   kg_state_t  state_reg, state_next;
   logic [2:0] index_reg, index_next;
   logic       close_reg, close_next;
   logic [3:0] gap_cnt_reg, gap_cnt_next;
   logic [2:0] last_index;

   assign last_index = close_reg ? CLOSE_LAST_INDEX : OPEN_LAST_INDEX;

   // State, word index, sequence type and gap counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= KG_IDLE;
         index_reg   <= 3'd0;
         close_reg   <= 1'b0;
         gap_cnt_reg <= 4'd0;
      end else begin
         state_reg   <= state_next;
         index_reg   <= index_next;
         close_reg   <= close_next;
         gap_cnt_reg <= gap_cnt_next;
      end
   end

   // Next-state logic; a lost grant restarts from word 0 since the detector loses its place
   always_comb begin
      state_next   = state_reg;
      index_next   = index_reg;
      close_next   = close_reg;
      gap_cnt_next = gap_cnt_reg;
      case (state_reg)
         KG_IDLE: begin
            if (open_req) begin
               state_next = KG_REQ;
               close_next = 1'b0;
               index_next = 3'd0;
            end else if (close_req) begin
               state_next = KG_REQ;
               close_next = 1'b1;
               index_next = 3'd0;
            end
         end
         KG_REQ: begin
            if (bus.bus_grant) begin
               state_next = KG_STORE;
            end
         end
         KG_STORE: begin
            if (!bus.bus_grant) begin
               state_next = KG_REQ;
               index_next = 3'd0;
            end else if (bus.Dmem2gen_response != 4'd0) begin
               if (index_reg == last_index) begin
                  state_next = KG_DONE;
               end else begin
                  index_next = index_reg + 3'd1;
                  if (GAP_CYCLES > 0) begin
                     state_next   = KG_GAP;
                     gap_cnt_next = 4'd0;
                  end
               end
            end
         end
         KG_GAP: begin
            if (!bus.bus_grant) begin
               state_next = KG_REQ;
               index_next = 3'd0;
            end else if (gap_cnt_reg == GAP_LAST) begin
               state_next = KG_STORE;
            end else begin
               gap_cnt_next = gap_cnt_reg + 4'd1;
            end
         end
         KG_DONE: begin
            state_next = KG_IDLE;
         end
         default: begin
            state_next = KG_IDLE;
         end
      endcase
   end

   // Moore output decode: word table lookup and bus/status signals from registered state
   always_comb begin
      logic [63:0] word_sel;
      word_sel = 64'd0;
      case ({close_reg, index_reg})
         4'b0_000: word_sel = DOOR1;
         4'b0_001: word_sel = DOOR2;
         4'b0_010: word_sel = DOOR3;
         4'b0_011: word_sel = DOOR4;
         4'b0_100: word_sel = DOOR5;
         4'b0_101: word_sel = DOOR6;
         4'b0_110: word_sel = DOOR7;
         4'b1_000: word_sel = CLOSE_DOOR1;
         4'b1_001: word_sel = CLOSE_DOOR2;
         4'b1_010: word_sel = CLOSE_DOOR3;
         default:  word_sel = 64'd0;
      endcase

      bus.gen2Dmem_command = BUS_NONE;
      bus.gen2Dmem_addr    = 64'd0;
      bus.gen2Dmem_data    = 64'd0;
      if (state_reg == KG_STORE) begin
         bus.gen2Dmem_command = BUS_STORE;
         bus.gen2Dmem_addr    = BASE_ADDR + {58'd0, index_reg, 3'b000};
         bus.gen2Dmem_data    = word_sel;
      end
      bus.gen_bus_req = (state_reg == KG_REQ) || (state_reg == KG_STORE) || (state_reg == KG_GAP);
      busy            = (state_reg != KG_IDLE);
      done            = (state_reg == KG_DONE);
      seq_is_close    = close_reg;
   end

endmodule

// File: tb/tb_knock_seq_gen.sv
// Bench for knock_seq_gen: two instances (no gap, 2-cycle gap) share one stimulus stream.
// Each request pushes the expected store stream into a per-instance queue; a negedge
// monitor pops on every accepted store and checks done/busy/gap/retry/reset behaviour.
module tb_knock_seq_gen;

   localparam logic [1:0]  CMD_NONE  = 2'd0;
   localparam logic [1:0]  CMD_STORE = 2'd2;
   localparam logic [63:0] BASE      = 64'h0000_0000_0000_1000;
   localparam int          GAP_A     = 0;
   localparam int          GAP_B     = 2;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      bit          last;
   } exp_t;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       open_req  = 1'b0;
   logic       close_req = 1'b0;
   logic       bus_grant = 1'b0;
   logic [3:0] resp      = 4'd0;

   // stimulus controls, written by the main initial block only
   bit         resp_mode   = 1'b0;
   bit         grant_mode  = 1'b0;
   logic [3:0] resp_fixed  = 4'h1;
   logic       grant_fixed = 1'b1;
   int         tmo_count   = 0;

   // monitor-owned state
   int   n_checks = 0;
   int   n_fail   = 0;
   int   tmo_seen = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   bit   idle_m     [2] = '{1'b1, 1'b1};
   bit   done_next  [2] = '{1'b0, 1'b0};
   bit   last_close [2] = '{1'b0, 1'b0};
   bit   rst_seen   [2] = '{1'b0, 1'b0};
   bit   hold_v     [2] = '{1'b0, 1'b0};
   bit   gap_on     [2] = '{1'b0, 1'b0};
   int   gap_n      [2] = '{0, 0};
   logic [1:0]  hold_cmd  [2];
   logic [63:0] hold_addr [2];
   logic [63:0] hold_data [2];

   always #5 clock = ~clock;

   knock_seq_gen_if bus_a ();
   knock_seq_gen_if bus_b ();
   assign bus_a.bus_grant         = bus_grant;
   assign bus_a.Dmem2gen_response = resp;
   assign bus_b.bus_grant         = bus_grant;
   assign bus_b.Dmem2gen_response = resp;

   logic busy_a, done_a, close_a, busy_b, done_b, close_b;

   knock_seq_gen #(.BASE_ADDR(BASE), .GAP_CYCLES(GAP_A)) dut_a (
      .clock        (clock),
      .reset        (reset),
      .open_req     (open_req),
      .close_req    (close_req),
      .bus          (bus_a),
      .busy         (busy_a),
      .done         (done_a),
      .seq_is_close (close_a)
   );

   knock_seq_gen #(.BASE_ADDR(BASE), .GAP_CYCLES(GAP_B)) dut_b (
      .clock        (clock),
      .reset        (reset),
      .open_req     (open_req),
      .close_req    (close_req),
      .bus          (bus_b),
      .busy         (busy_b),
      .done         (done_b),
      .seq_is_close (close_b)
   );

   logic [1:0]  cmd_o   [2];
   logic [63:0] addr_o  [2];
   logic [63:0] data_o  [2];
   logic        req_o   [2];
   logic        busy_o  [2];
   logic        done_o  [2];
   logic        close_o [2];
   assign cmd_o[0]   = bus_a.gen2Dmem_command;
   assign cmd_o[1]   = bus_b.gen2Dmem_command;
   assign addr_o[0]  = bus_a.gen2Dmem_addr;
   assign addr_o[1]  = bus_b.gen2Dmem_addr;
   assign data_o[0]  = bus_a.gen2Dmem_data;
   assign data_o[1]  = bus_b.gen2Dmem_data;
   assign req_o[0]   = bus_a.gen_bus_req;
   assign req_o[1]   = bus_b.gen_bus_req;
   assign busy_o[0]  = busy_a;
   assign busy_o[1]  = busy_b;
   assign done_o[0]  = done_a;
   assign done_o[1]  = done_b;
   assign close_o[0] = close_a;
   assign close_o[1] = close_b;

   // ---------------- reference model helpers ----------------
   function automatic logic [63:0] ref_word(input bit is_close, input int k);
      logic [63:0] open_w  [7];
      logic [63:0] close_w [3];
      open_w  = '{64'h123f45a6f8e2b6c4, 64'h2a5c3d7e9b10f4e8, 64'h00001111cccc1111,
                  64'h7e6d5c4b3a291807, 64'ha5a55a5a0ff0f00f, 64'hfedcba9876543210,
                  64'h13487abacdd45487};
      close_w = '{64'h0011001100110011, 64'h1100110011001100, 64'hffaaffbbffccffdd};
      if (is_close) return close_w[k];
      return open_w[k];
   endfunction

   function automatic int gap_of(input int i);
      return (i == 0) ? GAP_A : GAP_B;
   endfunction

   // A (re)started sequence expects every word of its table from word 0 onward
   function automatic void load_seq(input int i, input bit is_close);
      exp_t e;
      int   n;
      n = is_close ? 3 : 7;
      if (i == 0) q_a.delete(); else q_b.delete();
      for (int k = 0; k < n; k++) begin
         e.addr = BASE + 64'(8 * k);
         e.data = ref_word(is_close, k);
         e.last = (k == n - 1);
         if (i == 0) q_a.push_back(e); else q_b.push_back(e);
      end
   endfunction

   function automatic int q_size(input int i);
      return (i == 0) ? q_a.size() : q_b.size();
   endfunction

   function automatic exp_t q_pop(input int i);
      if (i == 0) return q_a.pop_front();
      return q_b.pop_front();
   endfunction

   task automatic check(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d @%0t: got %h, want %h", name, i, $time, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic monitor_inst(input int i);
      exp_t e;
      bit   exp_done;
      if (rst_seen[i]) begin
         check("rst_command", i, 64'(cmd_o[i]), 64'(CMD_NONE));
         check("rst_addr", i, addr_o[i], 64'd0);
         check("rst_data", i, data_o[i], 64'd0);
         check("rst_bus_req", i, 64'(req_o[i]), 64'd0);
         check("rst_busy", i, 64'(busy_o[i]), 64'd0);
         check("rst_done", i, 64'(done_o[i]), 64'd0);
         check("rst_seq_is_close", i, 64'(close_o[i]), 64'd0);
         rst_seen[i] = 1'b0;
      end
      if (reset) begin
         if (i == 0) q_a.delete(); else q_b.delete();
         idle_m[i]     = 1'b1;
         done_next[i]  = 1'b0;
         gap_on[i]     = 1'b0;
         hold_v[i]     = 1'b0;
         last_close[i] = 1'b0;
         rst_seen[i]   = 1'b1;
      end else begin
         exp_done     = done_next[i];
         done_next[i] = 1'b0;
         check("done", i, 64'(done_o[i]), 64'(exp_done));
         check("busy", i, 64'(busy_o[i]), 64'(!idle_m[i]));
         if (idle_m[i] || exp_done)
            check("bus_req_off", i, 64'(req_o[i]), 64'd0);
         if (idle_m[i])
            check("idle_command", i, 64'(cmd_o[i]), 64'(CMD_NONE));
         if (exp_done)
            check("seq_is_close", i, 64'(close_o[i]), 64'(last_close[i]));
         // a rejected store must be presented again unchanged
         if (hold_v[i]) begin
            check("retry_command", i, 64'(cmd_o[i]), 64'(hold_cmd[i]));
            check("retry_addr", i, addr_o[i], hold_addr[i]);
            check("retry_data", i, data_o[i], hold_data[i]);
            check("retry_bus_req", i, 64'(req_o[i]), 64'd1);
            hold_v[i] = 1'b0;
         end
         // idle cycles between accepted stores
         if (gap_on[i]) begin
            if (cmd_o[i] == CMD_NONE) begin
               gap_n[i]++;
               check("gap_bus_req", i, 64'(req_o[i]), 64'd1);
            end else begin
               check("gap_len", i, 64'(gap_n[i]), 64'(gap_of(i)));
               gap_on[i] = 1'b0;
            end
         end
         // store on the bus while granted
         if (cmd_o[i] == CMD_STORE && bus_grant) begin
            check("store_seq_type", i, 64'(close_o[i]), 64'(last_close[i]));
            if (resp != 4'd0) begin
               check("store_expected", i, 64'(q_size(i) != 0), 64'd1);
               if (q_size(i) != 0) begin
                  e = q_pop(i);
                  check("store_addr", i, addr_o[i], e.addr);
                  check("store_data", i, data_o[i], e.data);
                  if (e.last) begin
                     done_next[i] = 1'b1;
                  end else begin
                     gap_on[i] = 1'b1;
                     gap_n[i]  = 0;
                  end
               end
            end else begin
               hold_v[i]    = 1'b1;
               hold_cmd[i]  = cmd_o[i];
               hold_addr[i] = addr_o[i];
               hold_data[i] = data_o[i];
            end
         end
         // requests start a sequence only when idle; OPEN wins a tie
         if (idle_m[i] && (open_req || close_req)) begin
            last_close[i] = !open_req;
            load_seq(i, last_close[i]);
            idle_m[i] = 1'b0;
         end
         if (exp_done) idle_m[i] = 1'b1;
         // any grant loss before completion restarts the sequence from word 0
         if (!bus_grant) begin
            gap_on[i] = 1'b0;
            hold_v[i] = 1'b0;
            if (!idle_m[i] && !done_next[i]) load_seq(i, last_close[i]);
         end
      end
   endtask

   always @(negedge clock) begin
      if (tmo_count != tmo_seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_bound @%0t: got %0d expired waits, want 0", $time, tmo_count - tmo_seen);
         tmo_seen = tmo_count;
      end
      for (int i = 0; i < 2; i++) monitor_inst(i);
   end

   // ---------------- drivers ----------------
   always @(posedge clock) begin
      #2;
      if (resp_mode) resp = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 15)) : 4'd0;
      else           resp = resp_fixed;
      if (grant_mode) bus_grant = ($urandom_range(0, 31) != 0);
      else            bus_grant = grant_fixed;
   end

   task automatic pulse(input bit o, input bit c);
      @(posedge clock); #1;
      open_req  = o;
      close_req = c;
      @(posedge clock); #1;
      open_req  = 1'b0;
      close_req = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clock); #1;
         n++;
      end while (!(idle_m[0] && idle_m[1]) && n < budget);
      if (!(idle_m[0] && idle_m[1])) tmo_count++;
   endtask

   task automatic wait_store_a(input logic [63:0] addr, input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!(cmd_o[0] == CMD_STORE && addr_o[0] == addr) && n < budget);
      if (!(cmd_o[0] == CMD_STORE && addr_o[0] == addr)) tmo_count++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int kind;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // OPEN then CLOSE, always accepted
      pulse(1'b1, 1'b0);
      wait_idle(200);
      pulse(1'b0, 1'b1);
      wait_idle(200);

      // three rejects on word 2 of OPEN
      pulse(1'b1, 1'b0);
      wait_store_a(BASE + 64'h10, 200);
      resp_fixed = 4'h0;
      repeat (3) begin @(posedge clock); #1; end
      resp_fixed = 4'h1;
      wait_idle(200);

      // grant dropped while word 4 is on the bus
      pulse(1'b1, 1'b0);
      wait_store_a(BASE + 64'h20, 200);
      grant_fixed = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      grant_fixed = 1'b1;
      wait_idle(300);

      // simultaneous requests, then a close_req while busy
      pulse(1'b1, 1'b1);
      repeat (2) @(posedge clock);
      pulse(1'b0, 1'b1);
      wait_idle(200);

      // reset in the middle of a sequence
      pulse(1'b1, 1'b0);
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (8) @(posedge clock);
      wait_idle(50);

      // randomized responses, grant drops, request types and interruptions
      resp_mode  = 1'b1;
      grant_mode = 1'b1;
      for (int it = 0; it < 30; it++) begin
         kind = int'($urandom_range(0, 2));
         pulse(kind != 1, kind != 0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 6)) @(posedge clock);
            pulse(kind == 1, kind != 1);
         end
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 10)) @(posedge clock);
            #1 reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
         end
         wait_idle(3000);
         repeat ($urandom_range(0, 3)) @(posedge clock);
      end
      resp_mode  = 1'b0;
      grant_mode = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
